// File: rtl/fc_layer_seq_if.sv
// fc_layer_seq_if
//   Word-addressed memory bus between the FC layer engine and the shared
//   feature memory. A read strobe returns data on mem_rdata one cycle later.
//   A write strobe stores mem_wdata at mem_addr in the same cycle.
//
//   mem_addr   engine -> memory  word address for the read or the write
//   mem_rd     engine -> memory  read strobe
//   mem_rdata  memory -> engine  read data, valid the cycle after mem_rd
//   mem_wr     engine -> memory  write strobe
//   mem_wdata  engine -> memory  write data
interface fc_layer_seq_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;

  // The engine drives the bus.
  modport master (
    output mem_addr,
    output mem_rd,
    output mem_wr,
    output mem_wdata,
    input  mem_rdata
  );

  // The memory answers it.
  modport slave (
    input  mem_addr,
    input  mem_rd,
    input  mem_wr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/fc_layer_seq.sv
// fc_layer_seq
//   Fully-connected layer engine with a single MAC. On a start it loads
//   NUM_IN inputs into a local buffer. For each output j it then reads the
//   bias b[j] and the weight row w[j][*] and accumulates in fixed point.
//   It writes the saturated result, with optional ReLU, to out_base+j.
//   It pulses finished once all NUM_OUT outputs have been written.
//
//   clk        clock, rising edge
//   reset      synchronous, active-high; aborts any run immediately
//   enable     start request, only honoured in IDLE
//   in_base    address of x[0]
//   w_base     address of w[0][0]; w[j][i] sits at w_base+j*NUM_IN+i
//   b_base     address of b[0]
//   out_base   address of y[0]
//   mem        memory bus (master side)
//   busy       high from the cycle after the start until finished
//   finished   one-cycle pulse after the last output write
module fc_layer_seq #(
  parameter int NUM_IN  = 120,
  parameter int NUM_OUT = 84,
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int ADDR_W  = 14,
  parameter int RELU    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] out_base,
  fc_layer_seq_if.master    mem,
  output logic              busy,
  output logic              finished
);

  // The accumulator is wide enough for NUM_IN full-scale products plus the
  // bias, so it cannot wrap.
  localparam int ACC_W  = 2 * DATA_W + $clog2(NUM_IN) + 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(NUM_IN + 2) + 1;
  localparam int OUT_W  = $clog2(NUM_OUT) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO     = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_LAST_RD = CNT_W'(NUM_IN);
  localparam logic [CNT_W-1:0] CNT_MAC_END = CNT_W'(NUM_IN + 1);
  localparam logic [OUT_W-1:0] LAST_OUT    = OUT_W'(NUM_OUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD_IN, MAC, WRITE, DONE} state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt;
  logic [OUT_W-1:0]        out_idx;
  logic [ADDR_W-1:0]       in_ptr, w_ptr, b_ptr, out_ptr;
  logic [DATA_W-1:0]       x_buf [NUM_IN];
  logic signed [ACC_W-1:0] acc;

  logic [ADDR_W-1:0]       addr_c;
  logic                    rd_c, wr_c;
  logic [DATA_W-1:0]       wdata_c;

  logic [PROD_W-1:0]       x_ext, w_ext, prod;
  logic signed [ACC_W-1:0] prod_ext, bias_ext, shifted;
  logic [ACC_W-DATA_W:0]   sat_hi;
  logic                    fits;
  logic [DATA_W-1:0]       sat_val, result;

  // Both operands are sign-extended to the full product width first. The
  // low PROD_W bits of the unsigned product are then the exact signed
  // product.
  assign x_ext    = {{DATA_W{x_buf[0][DATA_W-1]}}, x_buf[0]};
  assign w_ext    = {{DATA_W{mem.mem_rdata[DATA_W-1]}}, mem.mem_rdata};
  assign prod     = x_ext * w_ext;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-DATA_W){mem.mem_rdata[DATA_W-1]}}, mem.mem_rdata} << FRAC_W;

  // Arithmetic shift truncates toward -inf. The value fits in DATA_W bits
  // only when every bit from the sign down to bit DATA_W-1 agrees.
  assign shifted = acc >>> FRAC_W;
  assign sat_hi  = shifted[ACC_W-1:DATA_W-1];
  assign fits    = (&sat_hi) | ~(|sat_hi);

  // Saturate to the signed DATA_W range, then optionally clamp negatives.
  always_comb begin
    sat_val = shifted[DATA_W-1:0];
    if (!fits) begin
      sat_val = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                 : {1'b0, {(DATA_W-1){1'b1}}};
    end
    result = sat_val;
    if ((RELU != 0) && sat_val[DATA_W-1]) begin
      result = '0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and bus outputs. Reads happen only in LOAD_IN and MAC and
  // writes only in WRITE, so the two strobes never overlap.
  always_comb begin
    state_next = state;
    addr_c     = '0;
    rd_c       = 1'b0;
    wr_c       = 1'b0;
    wdata_c    = '0;
    busy       = 1'b0;
    finished   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = LOAD_IN;
      end
      LOAD_IN: begin
        busy = 1'b1;
        if (cnt < CNT_LAST_RD) begin
          rd_c   = 1'b1;
          addr_c = in_ptr;
        end
        if (cnt == CNT_LAST_RD) state_next = MAC;
      end
      MAC: begin
        busy = 1'b1;
        if (cnt == '0) begin
          rd_c   = 1'b1;
          addr_c = b_ptr;
        end else if (cnt <= CNT_LAST_RD) begin
          rd_c   = 1'b1;
          addr_c = w_ptr;
        end
        if (cnt == CNT_MAC_END) state_next = WRITE;
      end
      WRITE: begin
        busy       = 1'b1;
        wr_c       = 1'b1;
        addr_c     = out_ptr;
        wdata_c    = result;
        state_next = (out_idx == LAST_OUT) ? DONE : MAC;
      end
      DONE: begin
        finished   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem.mem_addr  = addr_c;
  assign mem.mem_rd    = rd_c;
  assign mem.mem_wr    = wr_c;
  assign mem.mem_wdata = wdata_c;

  // Counters, address pointers and the accumulator. Each pointer advances
  // as its word is issued. Weight rows are contiguous, so w_ptr runs
  // through the whole matrix without any multiply.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      out_idx <= '0;
      acc     <= '0;
      in_ptr  <= '0;
      w_ptr   <= '0;
      b_ptr   <= '0;
      out_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt     <= '0;
          out_idx <= '0;
          if (enable) begin
            in_ptr  <= in_base;
            w_ptr   <= w_base;
            b_ptr   <= b_base;
            out_ptr <= out_base;
          end
        end
        LOAD_IN: begin
          if (cnt < CNT_LAST_RD) in_ptr <= in_ptr + ADDR_W'(1);
          cnt <= (cnt == CNT_LAST_RD) ? '0 : cnt + CNT_ONE;
        end
        MAC: begin
          if (cnt == '0) b_ptr <= b_ptr + ADDR_W'(1);
          else if (cnt <= CNT_LAST_RD) w_ptr <= w_ptr + ADDR_W'(1);
          if (cnt == CNT_ONE) acc <= bias_ext;
          else if (cnt >= CNT_TWO) acc <= acc + prod_ext;
          cnt <= (cnt == CNT_MAC_END) ? '0 : cnt + CNT_ONE;
        end
        WRITE: begin
          out_ptr <= out_ptr + ADDR_W'(1);
          out_idx <= out_idx + OUT_W'(1);
          cnt     <= '0;
        end
        default: ;
      endcase
    end
  end

  // Input buffer as a shift register. Loading shifts each arriving x in at
  // the top, so x[0] ends up at the head. Each MAC step consumes the head
  // and rotates it to the top. After NUM_IN steps the buffer is back in its
  // original order for the next output.
  always_ff @(posedge clk) begin
    if (state == LOAD_IN && cnt != '0) begin
      for (int i = 0; i < NUM_IN - 1; i++) x_buf[i] <= x_buf[i+1];
      x_buf[NUM_IN-1] <= mem.mem_rdata;
    end else if (state == MAC && cnt >= CNT_TWO) begin
      for (int i = 0; i < NUM_IN - 1; i++) x_buf[i] <= x_buf[i+1];
      x_buf[NUM_IN-1] <= x_buf[0];
    end
  end

endmodule
